// File: rtl/framebuffer_reader.sv
// framebuffer_reader
//   Bus-master DMA that fetches a frame buffer in bursts of up to 16 words and
//   streams it out as 16-bit pixels (two per 32-bit word, low halfword first).
//   A 2**fifoDepthLog2-word FIFO decouples bus bursts from the pixel stream.
//
// Ports
//   clock, reset             rising-edge clock, async active-low reset
//   ci*                      custom-instruction config/status interface
//   requestBus/busGrant      bus arbitration
//   *Out                     bus master outputs (begin/end framing, address, be, burst size)
//   addressDataIn, dataValidIn, endTransactionIn, busErrorIn   slave responses
//   pixelData/pixelValid/pixelReady   pixel stream handshake
//   frameStart, lineEnd      frame/line markers qualifying pixelData
//
// Optional feature macro: FRAMEBUFFER_READER_UNDERRUN_EN
//   When defined, an 8-bit saturating underrun counter is readable via CI 7
//   and cleared by any CI 4 (control) write. Otherwise CI 7 returns 0.

module framebuffer_reader #(
   parameter logic [7:0] customInstructionId = 8'd0,
   parameter int         fifoDepthLog2       = 5
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        ciStart,
   input  logic        ciCke,
   input  logic [7:0]  ciN,
   input  logic [31:0] ciValueA,
   input  logic [31:0] ciValueB,
   output logic [31:0] ciResult,
   output logic        ciDone,
   output logic        requestBus,
   input  logic        busGrant,
   output logic        beginTransactionOut,
   output logic        endTransactionOut,
   output logic        readNotWriteOut,
   output logic [31:0] addressDataOut,
   output logic [3:0]  byteEnablesOut,
   output logic [7:0]  burstSizeOut,
   input  logic [31:0] addressDataIn,
   input  logic        dataValidIn,
   input  logic        endTransactionIn,
   input  logic        busErrorIn,
   output logic [15:0] pixelData,
   output logic        pixelValid,
   input  logic        pixelReady,
   output logic        frameStart,
   output logic        lineEnd
);

   localparam int AW    = fifoDepthLog2;
   localparam int DEPTH = 1 << AW;
   localparam logic [AW:0] C_DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] C_BURST = {{(AW-4){1'b0}}, 5'd16};

   typedef enum logic [2:0] {
      IDLE, REQUEST_BUS, INIT_BURST, RECEIVE, ERROR, DONE_BURST
   } state_t;

   // ---------------- CI decode ----------------
   logic       w_myCi, w_ctrlWr, w_startFrame, w_doneRd;
   logic [2:0] w_cmd;
   logic       w_unused;

   assign w_myCi   = ciStart & ciCke & (ciN == customInstructionId);
   assign w_cmd    = ciValueA[2:0];
   assign w_ctrlWr = w_myCi & (w_cmd == 3'd4);
   assign w_doneRd = w_myCi & (w_cmd == 3'd5);
   assign ciDone   = w_myCi;
   assign w_unused = &{1'b0, ciValueA[31:3]};

   // ---------------- configuration ----------------
   logic [31:0] r_base;
   logic [8:0]  r_wpl;
   logic [10:0] r_lpf;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_base <= 32'd0;
         r_wpl  <= 9'd0;
         r_lpf  <= 11'd0;
      end else if (w_myCi) begin
         case (w_cmd)
            3'd1:    r_base <= {ciValueB[31:2], 2'b00};
            3'd2:    r_wpl  <= ciValueB[8:0];
            3'd3:    r_lpf  <= ciValueB[10:0];
            default: ;
         endcase
      end
   end

   // ---------------- bus-side state ----------------
   state_t      r_state;
   logic        r_frameActive, r_continuous, r_doneFlag;
   logic [7:0]  r_errorCount;
   logic [31:0] r_addr;
   logic [8:0]  r_wordsLeft, r_curWpl;
   logic [10:0] r_lineCnt, r_curLpf;
   logic [4:0]  r_burstN, r_rxCnt;
   logic        r_requestBus, r_begin, r_end, r_rnw;
   logic [31:0] r_addrOut;
   logic [3:0]  r_be;
   logic [7:0]  r_burstSize;

   logic [4:0]  w_n;
   logic [AW:0] r_count, w_free;
   logic        w_push, w_pop;
   logic [31:0] w_pushData;

   // A new frame is only latched when none is running; a running frame
   // picks up new geometry when it wraps in continuous mode.
   assign w_startFrame = w_ctrlWr & ~r_frameActive &
                         ((ciValueB[1:0] == 2'b01) | (ciValueB[1:0] == 2'b10));

   assign w_n    = (r_wordsLeft > 9'd16) ? 5'd16 : r_wordsLeft[4:0];
   assign w_free = C_DEPTH - r_count;

   // Error padding pushes zero words so the pixel-side line geometry stays intact.
   assign w_push = ((r_state == RECEIVE) & dataValidIn & ~busErrorIn & (r_rxCnt != 5'd0)) |
                   ((r_state == ERROR) & (r_rxCnt != 5'd0));
   assign w_pushData = (r_state == ERROR) ? 32'd0 : addressDataIn;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_state       <= IDLE;
         r_frameActive <= 1'b0;
         r_continuous  <= 1'b0;
         r_doneFlag    <= 1'b1;
         r_errorCount  <= 8'd0;
         r_addr        <= 32'd0;
         r_wordsLeft   <= 9'd0;
         r_curWpl      <= 9'd0;
         r_lineCnt     <= 11'd0;
         r_curLpf      <= 11'd0;
         r_burstN      <= 5'd0;
         r_rxCnt       <= 5'd0;
         r_requestBus  <= 1'b0;
         r_begin       <= 1'b0;
         r_end         <= 1'b0;
         r_rnw         <= 1'b0;
         r_addrOut     <= 32'd0;
         r_be          <= 4'd0;
         r_burstSize   <= 8'd0;
      end else begin
         r_begin     <= 1'b0;
         r_end       <= 1'b0;
         r_rnw       <= 1'b0;
         r_addrOut   <= 32'd0;
         r_be        <= 4'd0;
         r_burstSize <= 8'd0;

         if (w_doneRd) r_doneFlag <= 1'b0;

         if (w_ctrlWr) begin
            case (ciValueB[1:0])
               2'b01:   r_continuous <= 1'b1;
               2'b10,
               2'b00:   r_continuous <= 1'b0;
               default: ;
            endcase
         end

         if (w_startFrame) begin
            r_frameActive <= 1'b1;
            r_doneFlag    <= 1'b0;
            r_addr        <= r_base;
            r_lineCnt     <= r_lpf;
            r_wordsLeft   <= r_wpl;
            r_curWpl      <= r_wpl;
            r_curLpf      <= r_lpf;
         end

         case (r_state)
            IDLE: begin
               // A full burst of space is reserved before asking for the bus.
               if (r_frameActive && (r_curLpf != 11'd0) && (r_curWpl != 9'd0) &&
                   (w_free >= C_BURST)) begin
                  r_requestBus <= 1'b1;
                  r_state      <= REQUEST_BUS;
               end
            end
            REQUEST_BUS: begin
               if (busGrant) begin
                  r_requestBus <= 1'b0;
                  r_state      <= INIT_BURST;
               end
            end
            INIT_BURST: begin
               r_burstN    <= w_n;
               r_rxCnt     <= w_n;
               r_begin     <= 1'b1;
               r_rnw       <= 1'b1;
               r_addrOut   <= r_addr;
               r_be        <= 4'hF;
               r_burstSize <= {3'd0, w_n - 5'd1};
               r_state     <= RECEIVE;
            end
            RECEIVE: begin
               if (busErrorIn) begin
                  r_end <= 1'b1;
                  if (r_errorCount != 8'hFF) r_errorCount <= r_errorCount + 8'd1;
                  r_state <= ERROR;
               end else begin
                  if (w_push) r_rxCnt <= r_rxCnt - 5'd1;
                  if (endTransactionIn) r_state <= DONE_BURST;
               end
            end
            ERROR: begin
               if (r_rxCnt != 5'd0) r_rxCnt <= r_rxCnt - 5'd1;
               else                 r_state <= DONE_BURST;
            end
            DONE_BURST: begin
               r_addr <= r_addr + {25'd0, r_burstN, 2'b00};
               if (r_wordsLeft == {4'd0, r_burstN}) begin
                  r_wordsLeft <= r_curWpl;
                  if (r_lineCnt == 11'd1) begin
                     r_doneFlag <= 1'b1;
                     if (r_continuous) begin
                        r_addr      <= r_base;
                        r_lineCnt   <= r_lpf;
                        r_wordsLeft <= r_wpl;
                        r_curWpl    <= r_wpl;
                        r_curLpf    <= r_lpf;
                     end else begin
                        r_frameActive <= 1'b0;
                     end
                  end else begin
                     r_lineCnt <= r_lineCnt - 11'd1;
                  end
               end else begin
                  r_wordsLeft <= r_wordsLeft - {4'd0, r_burstN};
               end
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign requestBus          = r_requestBus;
   assign beginTransactionOut = r_begin;
   assign endTransactionOut   = r_end;
   assign readNotWriteOut     = r_rnw;
   assign addressDataOut      = r_addrOut;
   assign byteEnablesOut      = r_be;
   assign burstSizeOut        = r_burstSize;

   // ---------------- FIFO ----------------
   logic [31:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wrPtr, r_rdPtr;

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wrPtr] <= w_pushData;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
         if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- pixel side ----------------
   logic        r_half;
   logic [9:0]  r_pxCnt;
   logic [10:0] r_pxLine;
   logic [31:0] w_word;
   logic        w_accept, w_lineLast;

   assign pixelValid = (r_count != '0);
   assign w_accept   = pixelValid & pixelReady;
   assign w_pop      = w_accept & r_half;   // word leaves after its high halfword
   assign w_word     = r_mem[r_rdPtr];
   assign w_lineLast = (r_pxCnt == ({r_curWpl, 1'b0} - 10'd1));

   assign pixelData  = pixelValid ? (r_half ? w_word[31:16] : w_word[15:0]) : 16'd0;
   assign frameStart = pixelValid & (r_pxCnt == 10'd0) & (r_pxLine == 11'd0);
   assign lineEnd    = pixelValid & w_lineLast;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_half   <= 1'b0;
         r_pxCnt  <= 10'd0;
         r_pxLine <= 11'd0;
      end else begin
         if (w_accept) r_half <= ~r_half;
         if (w_startFrame) begin
            r_pxCnt  <= 10'd0;
            r_pxLine <= 11'd0;
         end else if (w_accept) begin
            if (w_lineLast) begin
               r_pxCnt  <= 10'd0;
               r_pxLine <= (r_pxLine == r_curLpf - 11'd1) ? 11'd0 : r_pxLine + 11'd1;
            end else begin
               r_pxCnt <= r_pxCnt + 10'd1;
            end
         end
      end
   end

   // ---------------- underrun counter (optional) ----------------
`ifdef FRAMEBUFFER_READER_UNDERRUN_EN
   logic [7:0] r_underrunCount;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_underrunCount <= 8'd0;
      end else if (w_ctrlWr) begin
         r_underrunCount <= 8'd0;
      end else if (pixelReady && !pixelValid && r_frameActive && (r_underrunCount != 8'hFF)) begin
         r_underrunCount <= r_underrunCount + 8'd1;
      end
   end
`endif

   // ---------------- CI result ----------------
   always_comb begin
      ciResult = 32'd0;
      if (w_myCi) begin
         case (w_cmd)
            3'd0:    ciResult = r_base;
            3'd5:    ciResult = {31'd0, r_doneFlag};
            3'd6:    ciResult = {24'd0, r_errorCount};
`ifdef FRAMEBUFFER_READER_UNDERRUN_EN
            3'd7:    ciResult = {24'd0, r_underrunCount};
`endif
            default: ciResult = 32'd0;
         endcase
      end
   end

endmodule

// File: doc/framebuffer_reader.md
Name: framebuffer_reader

Overview:
- Bus-master DMA that reads a frame buffer from memory in bursts and streams it out as 16-bit pixels to a display/pixel sink.
- Read-side counterpart of the camera grabber: same bus-master handshake and same custom-instruction (CI) configuration style.
- Same word packing as the grabber: each 32-bit word holds two pixels, low halfword first.
- A 32-word internal FIFO decouples bus bursts from the pixel stream.

Parameters:
- customInstructionId, 8'd0, CI number this block responds to.
- fifoDepthLog2, 5, log2 of FIFO depth in 32-bit words; minimum 5.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- ciStart, ciCke  in  1 each  CI start and clock enable.
- ciN  in  8  CI number.
- ciValueA, ciValueB  in  32 each  CI operands.
- ciResult  out  32  CI result; 0 when the CI is not addressed.
- ciDone  out  1  CI done.
- requestBus  out  1  bus request.
- busGrant  in  1  bus grant.
- beginTransactionOut, endTransactionOut  out  1 each  transaction framing.
- readNotWriteOut  out  1  high during a begin cycle (read).
- addressDataOut  out  32  burst address in the begin cycle; 0 otherwise.
- byteEnablesOut  out  4  4'hF in the begin cycle; 0 otherwise.
- burstSizeOut  out  8  words-1 in the begin cycle; 0 otherwise.
- addressDataIn  in  32  read data.
- dataValidIn, endTransactionIn, busErrorIn  in  1 each  slave responses.
- pixelData  out  16  output pixel.
- pixelValid  out  1  pixel handshake valid.
- pixelReady  in  1  pixel handshake ready.
- frameStart  out  1  high with the first pixel of a frame.
- lineEnd  out  1  high with the last pixel of a line.

Behaviour:
- Reset values: all outputs 0; state IDLE; base 0; wordsPerLine 0; linesPerFrame 0; FIFO empty; doneFlag 1; errorCount 0.
- CI handshake: myCi = ciStart & ciCke & (ciN == id); ciDone = myCi; single-cycle, combinational result.
- CI command selected by ciValueA[2:0]:
  - 0: read base.
  - 1: write base = {ciValueB[31:2], 2'b00}.
  - 2: write wordsPerLine = ciValueB[8:0].
  - 3: write linesPerFrame = ciValueB[10:0].
  - 4: control. ciValueB[1:0] = 01 starts continuous mode; 10 starts a single frame; 00 stops at the end of the current frame.
  - 5: read {31'd0, doneFlag}; self-clearing.
  - 6: read {24'd0, errorCount}.
  - Others return 0.
- Starting a frame (control write) clears doneFlag and latches the address pointer = base, lineCnt = linesPerFrame, wordsLeft = wordsPerLine.
- State machine:
  - IDLE → REQUEST_BUS when a frame is active, linesPerFrame ≠ 0 and wordsPerLine ≠ 0, and FIFO free space ≥ 16.
  - REQUEST_BUS: hold requestBus high until busGrant → INIT_BURST.
  - INIT_BURST (1 cycle): n = min(16, wordsLeft).
    - Next cycle: begin pulse, address, byte enables F, burstSizeOut = n-1, readNotWriteOut high.
    - → RECEIVE.
  - RECEIVE:
    - Each cycle dataValidIn is high, push addressDataIn into the FIFO and decrement rxCnt.
    - endTransactionIn → DONE_BURST.
    - busErrorIn → ERROR.
  - ERROR: assert endTransactionOut 1 cycle; errorCount += 1 (saturating at 255); push rxCnt zero words so line geometry is preserved → DONE_BURST.
  - DONE_BURST: address += 4n; wordsLeft -= n.
    - If wordsLeft = 0: reload wordsLeft and decrement lineCnt.
    - If lineCnt reaches 0: frame complete; set doneFlag; in continuous mode restart from base, otherwise stop.
    - → IDLE.
- Extra dataValidIn pulses (rxCnt = 0) are ignored; pushes never occur into a full FIFO because space is reserved before the request.
- Pixel side:
  - A pop occurs every second accepted pixel: low halfword is presented first, then high.
  - pixelValid is high whenever the current word is available; pixelData must stay stable while pixelValid & ~pixelReady.
  - frameStart and lineEnd are tracked by a pixel-side line and pixel counter (2 × wordsPerLine pixels per line) and qualify pixelData.
- Stop (00) takes effect at the end of the frame. Config writes during an active frame take effect at the next frame start.
- Reset mid-burst: immediate IDLE, FIFO flush, and bus outputs drop asynchronously.

Optional Feature:
- FRAMEBUFFER_READER_UNDERRUN_EN.
- Defined: an 8-bit saturating underrunCount increments each cycle that pixelReady is high, pixelValid is low, and a frame is in progress. CI command 7 reads it; CI command 4 clears it.
- Undefined: no counter; CI 7 returns 0.

Test Plan:
- Config base = 0x1000, wordsPerLine = 4, lines = 2, single frame; slave returns incrementing words.
  - → Bursts at 0x1000 and 0x1010, each burstSizeOut = 3.
  - → 16 pixels out, low halfword first; frameStart on pixel 0; lineEnd on pixels 7 and 15.
  - → CI 5 returns 1.
- wordsPerLine = 20 → bursts of 16 then 4 (burstSizeOut 15 then 3); second burst address = base + 64.
- Hold pixelReady = 0 → at most 2 bursts outstanding before the FIFO-space check stalls requestBus; no data lost on release.
- busErrorIn after 2 words of a 4-word burst → endTransactionOut pulse; pixels 4..7 are 0; CI 6 returns 1.
- Continuous mode, 3 frames → address wraps to base each frame; then control 00 → stops after the current frame.
- Assert reset during RECEIVE → all outputs 0 immediately; after release, a new start re-reads from base.
